// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding
//   pc_sel_t      : next-PC select for fetch_pc_reg
//   NOP_INSTR     : instruction word held after reset (addi x0,x0,0)
//   *_LSB/_MSB    : bit positions of the decode fields peeled off the held word
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB       = 0;
    localparam int OP_MSB       = 6;
    localparam int FUNCT3_LSB   = 12;
    localparam int FUNCT3_MSB   = 14;
    localparam int FUNCT7B5_BIT = 30;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch unit.
//   clk, reset_n     : clock, asynchronous active-low reset (PC <= RESET_PC)
//   pc_sel           : hold / increment by 4 / load redirect target
//   redirect_target  : new PC; low two bits are masked so the PC stays word aligned
//   pc               : current fetch PC
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  pc_sel_t         pc_sel,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc_nxt;

    // Increment wraps naturally modulo 2^XLEN.
    always_comb begin
        pc_nxt = pc;
        case (pc_sel)
            PC_INC:      pc_nxt = pc + XLEN'(4);
            PC_REDIRECT: pc_nxt = redirect_target & ALIGN_MASK;
            default:     pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory and holds the returned word for decode until it is consumed.
//   clk, reset_n                    : clock, asynchronous active-low reset
//   imem_req/imem_addr              : fetch request and word-aligned address
//   imem_gnt                        : memory accepted the request
//   imem_rvalid/imem_rdata          : memory response
//   instr_valid/instr               : held instruction for decode
//   op/funct3/funct7b5              : decode fields of the held instruction
//   instr_pc/instr_pc_plus4         : PC of the held instruction and PC+4
//   decode_ready                    : decode consumes the held instruction
//   redirect/redirect_target        : taken branch/jump and its target
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | leaving reset, first edge moves to REQ
// REQ     | imem_req high at PC, waiting for imem_gnt
// WAIT    | request granted, waiting for imem_rvalid
// HOLD    | instruction presented, waiting for decode_ready or redirect
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            decode_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target
);

    fetch_state_t    state, state_nxt;
    pc_sel_t         pc_sel;
    logic            kill, kill_nxt;
    logic            capture;
    logic [XLEN-1:0] pc;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc_sel          (pc_sel),
        .redirect_target (redirect_target),
        .pc              (pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    // A redirect while a fetch is in flight marks that fetch as killed;
    // its response is swallowed and fetching restarts at the new PC.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        pc_sel    = PC_HOLD;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    pc_sel = PC_REDIRECT;
                end
                if (imem_gnt) begin
                    state_nxt = ST_WAIT;
                    kill_nxt  = redirect;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_sel = PC_REDIRECT;
                end
                if (imem_rvalid) begin
                    kill_nxt = 1'b0;
                    if (redirect || kill) begin
                        state_nxt = ST_REQ;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (redirect) begin
                    kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_sel    = PC_REDIRECT;
                    state_nxt = ST_REQ;
                end else if (decode_ready) begin
                    pc_sel    = PC_INC;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr    <= XLEN'(NOP_INSTR);
            instr_pc <= RESET_PC;
        end else if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
        end
    end

    assign imem_req       = (state == ST_REQ);
    assign imem_addr      = pc;
    assign instr_valid    = (state == ST_HOLD);
    assign instr_pc_plus4 = instr_pc + XLEN'(4);
    assign op             = instr[OP_MSB:OP_LSB];
    assign funct3         = instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7b5       = instr[FUNCT7B5_BIT];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter XLEN, default 32: address and instruction width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  XLEN  word-aligned fetch address; valid while imem_req=1.
REQ-007 imem_gnt  in  1  memory accepted the request this cycle.
REQ-008 imem_rvalid  in  1  response data valid.
REQ-009 imem_rdata  in  XLEN  fetched instruction word.
REQ-010 instr_valid  out  1  instruction presented to decode/Controller.
REQ-011 instr  out  XLEN  held instruction word.
REQ-012 op  out  7  instr[6:0], to Controller op.
REQ-013 funct3  out  3  instr[14:12], to Controller funct3.
REQ-014 funct7b5  out  1  instr[30], to Controller funct7b5.
REQ-015 instr_pc / instr_pc_plus4  out  XLEN each  PC of held instruction and PC+4.
REQ-016 decode_ready  in  1  downstream consumes instruction when instr_valid=1.
REQ-017 redirect  in  1  taken branch/jump (Controller PCSrc).
REQ-018 redirect_target  in  XLEN  new PC; bits [1:0] ignored and forced to 0.

Function
REQ-019 FSM states IDLE, REQ, WAIT, HOLD; at most one outstanding fetch.
REQ-020 IDLE -> REQ on first edge after reset release; no other IDLE entry.
REQ-021 REQ: imem_req=1, imem_addr=PC; imem_gnt=1 -> WAIT next cycle; otherwise remain, address stable.
REQ-022 WAIT: imem_rvalid=1 and not killed -> capture imem_rdata into instr, instr_pc=PC, go HOLD.
REQ-023 HOLD: instr_valid=1, outputs stable; decode_ready=1 -> PC<=PC+4, go REQ next cycle.
REQ-024 Memory response SHALL NOT be accepted in the same cycle as imem_gnt; rvalid outside WAIT is ignored.
REQ-025 Redirect in REQ, no gnt: PC<=target, stay REQ; address changes next cycle.
REQ-026 Redirect in REQ with gnt same cycle: PC<=target, kill flag set, go WAIT.
REQ-027 Redirect in WAIT: PC<=target, kill flag set; on rvalid with kill set, discard data, clear kill, go REQ.
REQ-028 Redirect in HOLD: redirect wins over decode_ready, instr_valid drops next cycle, PC<=target, go REQ.
REQ-029 Redirect and rvalid in same WAIT cycle: data discarded, PC<=target, go REQ.
REQ-030 PC+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0).
REQ-031 Latency: REQ-to-instr_valid = gnt wait + 1 + memory latency; back-to-back throughput 1 instruction per 3 cycles minimum.

Reset
REQ-032 reset_n=0 forces immediately: state=IDLE, PC=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, kill=0, instr_pc=RESET_PC.
REQ-033 Reset mid-fetch abandons the outstanding request; any later rvalid is ignored until a new REQ grant.

Structure
REQ-034 Package fetch_pkg holds the state enum, NOP constant 32'h0000_0013, and field bit-position constants for op/funct3/funct7b5.
REQ-035 One sub-module, fetch_pc_reg: PC register with async reset, next-PC select (hold, +4, redirect target) and alignment masking.

Verification
REQ-036 Reset release, RESET_PC=0, gnt=1, 1-cycle memory -> imem_addr 0x0,0x4,0x8 in order; instr/op match imem_rdata each HOLD.
REQ-037 imem_gnt held 0 for 3 cycles -> imem_req stays 1, imem_addr constant 0x0, instr_valid 0.
REQ-038 Redirect to 0x103 while in WAIT -> response for old PC dropped, next imem_addr=0x100, instr_pc=0x100.
REQ-039 Redirect to 0x40 and decode_ready both high in HOLD -> next imem_addr=0x40, not PC+4.
REQ-040 PC=0xFFFF_FFFC consumed -> next imem_addr=0x0.
REQ-041 reset_n pulsed low during WAIT -> instr_valid 0 at once, late rvalid ignored, fetch restarts at RESET_PC.
